// File: rtl/lfsr_pkg.sv
`default_nettype none
//============================================================================
// Module      : lfsr_pkg
// Description : Shared types and single-step helpers for the LFSR generator.
//               Step functions work on a c_MAX_N-wide container; callers
//               zero-extend an N-bit register into it and truncate the
//               result back to N bits, so any N in [2, c_MAX_N] is served.
// Revision    : 1.0 - initial parametrised release
//============================================================================
package lfsr_pkg;

    localparam int c_MAX_N = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    // Fibonacci step: the parity of the tapped bits enters at the top of an
    // n-bit register while everything shifts one place toward bit 0.
    // Bits at and above n must be zero on entry and stay zero on exit.
    function automatic logic [c_MAX_N-1:0] lfsr_fib_step(
        input logic [c_MAX_N-1:0] s,
        input logic [c_MAX_N-1:0] taps,
        input int unsigned        n
    );
        logic nb;
        nb = ^(s & taps);
        return (s >> 1) | ({{(c_MAX_N-1){1'b0}}, nb} << (n - 1));
    endfunction

    // Galois step: the bit leaving at position 0 toggles every tapped bit.
    function automatic logic [c_MAX_N-1:0] lfsr_galois_step(
        input logic [c_MAX_N-1:0] s,
        input logic [c_MAX_N-1:0] taps
    );
        return (s >> 1) ^ ({c_MAX_N{s[0]}} & taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step_unroll.sv
`default_nettype none
//============================================================================
// Module      : lfsr_step_unroll
// Description : Combinational W-step unroll of an N-bit right-shifting LFSR.
//               o_word[k] is s[0] before step k; o_s_next is the register
//               after all W steps. i_mode = 1 selects Galois stepping.
// Ports       : i_s, i_taps (N), i_mode (1) -> o_word (W), o_s_next (N)
// Revision    : 1.0 - initial parametrised release
//============================================================================
module lfsr_step_unroll
    import lfsr_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic [N-1:0] i_s,
    input  logic [N-1:0] i_taps,
    input  logic         i_mode,
    output logic [W-1:0] o_word,
    output logic [N-1:0] o_s_next
);

    always_comb begin
        logic [N-1:0] w_cur;
        w_cur  = i_s;
        o_word = '0;
        for (int k = 0; k < W; k++) begin
            o_word[k] = w_cur[0];
            if (i_mode) begin
                w_cur = N'(lfsr_galois_step(c_MAX_N'(w_cur), c_MAX_N'(i_taps)));
            end else begin
                w_cur = N'(lfsr_fib_step(c_MAX_N'(w_cur), c_MAX_N'(i_taps), N));
            end
        end
        o_s_next = w_cur;
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
//============================================================================
// Module      : lfsr_gen
// Description : W-bit-per-clock PRBS source built on an N-bit right-shifting
//               LFSR with runtime-loadable taps/seed, valid/ready output and
//               all-zero lock-up detection (halts until reconfigured).
//               Optional macro LFSR_GALOIS_EN adds cfg_galois_i, latched on
//               cfg_load_i, selecting Galois instead of Fibonacci stepping.
// Ports       : clk_i, reset_ni (async, active-low)
//               cfg_load_i, cfg_taps_i[N], cfg_seed_i[N] (+ cfg_galois_i)
//               enable_i, ready_i -> data_o[W] (bit 0 oldest), valid_o,
//               lockup_o
// Revision    : 1.0 - initial parametrised release
//============================================================================
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int           N            = 8,
    parameter int           W            = 1,
    parameter logic [N-1:0] DEFAULT_TAPS = N'(8'b0000_0011),
    parameter logic [N-1:0] DEFAULT_SEED = N'(8'b0000_0001)
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         cfg_load_i,
    input  logic [N-1:0] cfg_taps_i,
    input  logic [N-1:0] cfg_seed_i,
`ifdef LFSR_GALOIS_EN
    input  logic         cfg_galois_i,
`endif
    input  logic         enable_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         lockup_o
);

    lfsr_state_e  r_state, w_state_nxt;
    logic [N-1:0] r_s, w_s_nxt;
    logic [N-1:0] r_taps, w_taps_nxt;
    logic [W-1:0] r_data, w_data_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_lockup, w_lockup_nxt;

    logic [W-1:0] w_word;
    logic [N-1:0] w_s_adv;
    logic         w_mode;
    logic         w_s_zero;
    logic         w_produce;

`ifdef LFSR_GALOIS_EN
    logic r_galois;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_galois <= 1'b0;
        end else if (cfg_load_i) begin
            r_galois <= cfg_galois_i;
        end
    end

    assign w_mode = r_galois;
`else
    assign w_mode = 1'b0;
`endif

    lfsr_step_unroll #(
        .N (N),
        .W (W)
    ) u_unroll (
        .i_s      (r_s),
        .i_taps   (r_taps),
        .i_mode   (w_mode),
        .o_word   (w_word),
        .o_s_next (w_s_adv)
    );

    assign w_s_zero  = (r_s == '0);
    // Output register may only be overwritten when empty or being consumed;
    // ready_i only gates register enables, never feeds data_o directly.
    assign w_produce = !r_valid || ready_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state  <= IDLE;
            r_s      <= DEFAULT_SEED;
            r_taps   <= DEFAULT_TAPS;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s      <= w_s_nxt;
            r_taps   <= w_taps_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_lockup <= w_lockup_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_s_nxt      = r_s;
        w_taps_nxt   = r_taps;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;
        w_lockup_nxt = r_lockup;

        if (cfg_load_i) begin
            // Reconfiguration wins over everything, including a word that is
            // being accepted this very cycle. A zero seed is left for the
            // next enable to detect.
            w_taps_nxt   = cfg_taps_i;
            w_s_nxt      = cfg_seed_i;
            w_valid_nxt  = 1'b0;
            w_lockup_nxt = 1'b0;
            w_state_nxt  = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_valid_nxt = 1'b0;
                    if (enable_i) begin
                        if (w_s_zero) begin
                            w_lockup_nxt = 1'b1;
                            w_state_nxt  = LOCKED;
                        end else begin
                            w_data_nxt  = w_word;
                            w_valid_nxt = 1'b1;
                            w_s_nxt     = w_s_adv;
                            w_state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_produce) begin
                        // Dropping enable takes precedence over lock-up; a
                        // zero register is then caught on the next enable.
                        if (!enable_i) begin
                            w_valid_nxt = 1'b0;
                            w_state_nxt = IDLE;
                        end else if (w_s_zero) begin
                            w_valid_nxt  = 1'b0;
                            w_lockup_nxt = 1'b1;
                            w_state_nxt  = LOCKED;
                        end else begin
                            w_data_nxt  = w_word;
                            w_valid_nxt = 1'b1;
                            w_s_nxt     = w_s_adv;
                        end
                    end
                end
                LOCKED: begin
                    w_valid_nxt  = 1'b0;
                    w_lockup_nxt = 1'b1;
                end
                default: begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign data_o   = r_data;
    assign valid_o  = r_valid;
    assign lockup_o = r_lockup;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
//============================================================================
// Module      : tb_lfsr_gen
// Description : Self-checking bench for lfsr_gen. Two instances (N=8 with
//               W=8 and W=3) share one stimulus stream; each is compared
//               every cycle against a behavioural model of the generator.
// Revision    : 1.0 - initial release
//============================================================================
module tb_lfsr_gen;

    localparam int c_PH_IDLE   = 0;
    localparam int c_PH_RUN    = 1;
    localparam int c_PH_LOCKED = 2;

    logic       clk;
    logic       reset_n;
    logic       cfg_load;
    logic [7:0] cfg_taps;
    logic [7:0] cfg_seed;
    logic       enable;
    logic       ready;
`ifdef LFSR_GALOIS_EN
    logic       cfg_galois;
`endif

    logic [7:0] d8;
    logic [2:0] d3;
    logic       v8, v3, l8, l3;

    int total = 0;
    int bad   = 0;

    // Behavioural model, index 0 -> W=8 instance, index 1 -> W=3 instance
    logic [7:0] m_s    [2];
    logic [7:0] m_taps [2];
    logic [7:0] m_data [2];
    logic       m_valid[2];
    logic       m_lock [2];
    int         m_phase[2];
    bit         m_gal  [2];

    lfsr_gen #(.N(8), .W(8)) u_dut_w8 (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .cfg_load_i (cfg_load),
        .cfg_taps_i (cfg_taps),
        .cfg_seed_i (cfg_seed),
`ifdef LFSR_GALOIS_EN
        .cfg_galois_i (cfg_galois),
`endif
        .enable_i   (enable),
        .data_o     (d8),
        .valid_o    (v8),
        .ready_i    (ready),
        .lockup_o   (l8)
    );

    lfsr_gen #(.N(8), .W(3)) u_dut_w3 (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .cfg_load_i (cfg_load),
        .cfg_taps_i (cfg_taps),
        .cfg_seed_i (cfg_seed),
`ifdef LFSR_GALOIS_EN
        .cfg_galois_i (cfg_galois),
`endif
        .enable_i   (enable),
        .data_o     (d3),
        .valid_o    (v3),
        .ready_i    (ready),
        .lockup_o   (l3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] taps,
                                            input bit gal);
        if (gal) return (s >> 1) ^ (s[0] ? taps : 8'h00);
        return (s >> 1) | (($countones(s & taps) % 2 == 1) ? 8'h80 : 8'h00);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i]     = 8'h01;
            m_taps[i]  = 8'h03;
            m_data[i]  = 8'h00;
            m_valid[i] = 1'b0;
            m_lock[i]  = 1'b0;
            m_phase[i] = c_PH_IDLE;
            m_gal[i]   = 1'b0;
        end
    endtask

    task automatic model_produce(input int i);
        int w;
        w = (i == 0) ? 8 : 3;
        m_data[i] = 8'h00;
        for (int k = 0; k < w; k++) begin
            m_data[i][k] = m_s[i][0];
            m_s[i] = ref_step(m_s[i], m_taps[i], m_gal[i]);
        end
        m_valid[i] = 1'b1;
        m_phase[i] = c_PH_RUN;
    endtask

    // Predict the effect of the coming rising edge given current inputs.
    task automatic model_edge(input int i);
        if (cfg_load) begin
            m_taps[i]  = cfg_taps;
            m_s[i]     = cfg_seed;
            m_valid[i] = 1'b0;
            m_lock[i]  = 1'b0;
            m_phase[i] = c_PH_IDLE;
`ifdef LFSR_GALOIS_EN
            m_gal[i]   = cfg_galois;
`endif
        end else if (m_phase[i] == c_PH_IDLE) begin
            if (enable) begin
                if (m_s[i] == 8'h00) begin
                    m_lock[i]  = 1'b1;
                    m_phase[i] = c_PH_LOCKED;
                end else begin
                    model_produce(i);
                end
            end
        end else if (m_phase[i] == c_PH_RUN) begin
            if (!m_valid[i] || ready) begin
                if (!enable) begin
                    m_valid[i] = 1'b0;
                    m_phase[i] = c_PH_IDLE;
                end else if (m_s[i] == 8'h00) begin
                    m_valid[i] = 1'b0;
                    m_lock[i]  = 1'b1;
                    m_phase[i] = c_PH_LOCKED;
                end else begin
                    model_produce(i);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("w8_data",   64'(d8), 64'(m_data[0]));
        chk("w8_valid",  64'(v8), 64'(m_valid[0]));
        chk("w8_lockup", 64'(l8), 64'(m_lock[0]));
        chk("w3_data",   64'(d3), 64'(m_data[1][2:0]));
        chk("w3_valid",  64'(v3), 64'(m_valid[1]));
        chk("w3_lockup", 64'(l3), 64'(m_lock[1]));
    endtask

    // Called at a falling edge with inputs already set for the next edge.
    task automatic cycle();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset_n  = 1'b0;
        cfg_load = 1'b0;
        cfg_taps = 8'h00;
        cfg_seed = 8'h00;
        enable   = 1'b0;
        ready    = 1'b0;
`ifdef LFSR_GALOIS_EN
        cfg_galois = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // First word one cycle after enable, then backpressure holds it
        enable = 1'b1;
        ready  = 1'b0;
        cycle();
        chk("first_word_w8", 64'(d8), 64'h01);
        chk("first_word_w3", 64'(d3), 64'h1);
        chk("first_valid",   64'(v8), 64'h1);
        repeat (5) cycle();
        chk("bp_hold_w8", 64'(d8), 64'h01);
        chk("bp_hold_valid", 64'(v8), 64'h1);
        ready = 1'b1;
        cycle();
        chk("second_word_w8", 64'(d8), 64'h81);
        chk("second_word_w3", 64'(d3), 64'h0);
        cycle();
        chk("third_word_w3", 64'(d3), 64'h4);

        // Reload while a word is pending: word dropped even with ready high
        ready = 1'b0;
        cycle();
        cfg_load = 1'b1;
        cfg_taps = 8'h1d;
        cfg_seed = 8'h5a;
        ready    = 1'b1;
        cycle();
        chk("load_drops_valid", 64'(v8), 64'h0);
        cfg_load = 1'b0;
        enable   = 1'b0;
        repeat (2) cycle();
        chk("idle_no_valid", 64'(v8), 64'h0);

        // Zero seed locks up on the next enable, cleared only by a reload
        cfg_load = 1'b1;
        cfg_seed = 8'h00;
        cfg_taps = 8'h03;
        cycle();
        cfg_load = 1'b0;
        enable   = 1'b1;
        cycle();
        chk("lockup_set", 64'(l8), 64'h1);
        repeat (4) cycle();
        chk("lockup_no_valid", 64'(v8), 64'h0);
        cfg_load = 1'b1;
        cfg_seed = 8'h01;
        cycle();
        chk("lockup_cleared", 64'(l8), 64'h0);
        cfg_load = 1'b0;
        cycle();
        chk("resume_word_w8", 64'(d8), 64'h01);
        repeat (3) cycle();

        // Asynchronous reset between clock edges while running
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_data",  64'(d8), 64'h0);
        chk("async_rst_valid", 64'(v8), 64'h0);
        chk("async_rst_lock",  64'(l8), 64'h0);
        chk("async_rst_data3", 64'(d3), 64'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        chk("restart_word_w8", 64'(d8), 64'h01);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            cfg_load = ($urandom_range(0, 15) == 0);
            cfg_taps = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            cfg_seed = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            enable   = ($urandom_range(0, 9) != 0);
            ready    = ($urandom_range(0, 3) != 0);
`ifdef LFSR_GALOIS_EN
            cfg_galois = 1'($urandom_range(0, 1));
`endif
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
